// File: rtl/anomaly_pkg.sv
// anomaly_pkg: shared encodings and constants for the anomaly detector.
// Input type codes, detector bit indices, fixed floors and shift amounts.
package anomaly_pkg;

  localparam logic [1:0] IT_PRICE  = 2'b00;
  localparam logic [1:0] IT_VOLUME = 2'b01;
  localparam logic [1:0] IT_BUY    = 2'b10;
  localparam logic [1:0] IT_SELL   = 2'b11;

  localparam int DET_SPIKE      = 0;
  localparam int DET_DRY        = 1;
  localparam int DET_SURGE      = 2;
  localparam int DET_VELOCITY   = 3;
  localparam int DET_IMBALANCE  = 4;
  localparam int DET_SPREAD     = 5;
  localparam int DET_VOLATILITY = 6;
  localparam int DET_FLASH      = 7;

  localparam int DRY_FLOOR   = 10;
  localparam int FLASH_FLOOR = 20;
  localparam int MAD_WEIGHT  = 7;
  localparam int MAD_SHIFT   = 3;
  localparam int GAIN_SHIFT  = 1;
  localparam int DRY_SHIFT   = 2;
  localparam int VOLA_SHIFT  = 2;
  localparam int IMB_SHIFT   = 2;
  localparam int SPREAD_MIN  = 2;

  function automatic logic [2:0] top_index(input logic [7:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (v[i]) r = 3'(i);
    return r;
  endfunction

endpackage

// File: rtl/anomaly_detector_p_ring.sv
// anom_ring_avg: ring buffer with running sum, average and fill count.
// The average tracks the updated sum so it reflects the newest sample.
module anom_ring_avg #(
  parameter int W         = 12,
  parameter int HIST_LOG2 = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] din,
  output logic [W-1:0] cur,
  output logic [W-1:0] avg,
  output logic         full
);

  localparam int DEPTH = 1 << HIST_LOG2;
  localparam int SW    = W + HIST_LOG2;
  localparam int FW    = HIST_LOG2 + 1;
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

  logic [W-1:0]         ring_q [DEPTH];
  logic [W-1:0]         ring_d [DEPTH];
  logic [HIST_LOG2-1:0] ptr_q, ptr_d;
  logic [SW-1:0]        sum_q, sum_d;
  logic [W-1:0]         cur_q, cur_d;
  logic [W-1:0]         avg_q, avg_d;
  logic [FW-1:0]        fill_q, fill_d;

  // Replace the oldest entry and fold the change into sum and average
  always_comb begin
    ring_d = ring_q;
    ptr_d  = ptr_q;
    sum_d  = sum_q;
    cur_d  = cur_q;
    avg_d  = avg_q;
    fill_d = fill_q;
    if (wr_en) begin
      ring_d[ptr_q] = din;
      ptr_d = ptr_q + 1'b1;
      sum_d = sum_q - SW'(ring_q[ptr_q]) + SW'(din);
      avg_d = W'(sum_d >> HIST_LOG2);
      cur_d = din;
      if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
    end
  end

  // History state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
      ptr_q  <= '0;
      sum_q  <= '0;
      cur_q  <= '0;
      avg_q  <= '0;
      fill_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= ring_d[i];
      ptr_q  <= ptr_d;
      sum_q  <= sum_d;
      cur_q  <= cur_d;
      avg_q  <= avg_d;
      fill_q <= fill_d;
    end
  end

  assign cur  = cur_q;
  assign avg  = avg_q;
  assign full = (fill_q == FILL_MAX);

endmodule

// File: rtl/anomaly_detector_p.sv
// anomaly_detector_p: eight parallel market detectors, registered alerts.
// Define ANOMALY_EVT_CNT_EN to count alert_any rising edges on evt_count.
module anomaly_detector_p #(
  parameter int PW         = 12,
  parameter int VW         = 12,
  parameter int HIST_LOG2  = 3,
  parameter int WIN_LOG2   = 8,
  parameter int MCW        = 5,
  parameter int OCW        = 3,
  parameter int VEL_THRESH = 30
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [1:0]    input_type,
  input  logic [PW-1:0] price_data,
  input  logic [VW-1:0] volume_data,
  input  logic          match_valid,
  input  logic [PW-1:0] spike_thresh,
  input  logic [PW-1:0] flash_thresh,
  input  logic [7:0]    det_enable,
  input  logic [7:0]    alert_ack,
  output logic [7:0]    alert_bitmap,
  output logic [7:0]    alert_sticky,
  output logic          alert_any,
  output logic [2:0]    alert_type,
  output logic          baseline_valid,
  output logic [7:0]    evt_count
);

  import anomaly_pkg::*;

  localparam int MW = PW + 3;
  localparam int PX = PW + 2;
  localparam int VX = VW + 2;
  localparam int OX = OCW + 2;
  localparam int RX = MCW + 2;
  localparam logic [OCW-1:0] OMAX = '1;
  localparam logic [MCW-1:0] MMAX = '1;

  logic            p_wr, v_wr, b_inc, s_inc;
  logic [PW-1:0]   p_cur, p_avg;
  logic [VW-1:0]   v_cur, v_avg;
  logic            p_full, v_full, base_ok;
  logic [PW-1:0]   prev_q, prev_d, mad_q, mad_d;
  logic [OCW-1:0]  buy_q, buy_d, sell_q, sell_d;
  logic [OCW-1:0]  buy_sat, sell_sat;
  logic [MCW-1:0]  mcnt_q, mcnt_d, rate_q, rate_d, mcnt_sat;
  logic [WIN_LOG2-1:0] timer_q, timer_d;
  logic [7:0]      det;
  logic [7:0]      bitmap_q, bitmap_d, sticky_q, sticky_d;
  logic            any_q, any_d;
  logic [2:0]      type_q, type_d;
  logic [PW-1:0]   p_dev, p_diff, vola_ex, fall;
  logic [MW-1:0]   mad_acc;

  assign p_wr  = in_valid && (input_type == IT_PRICE);
  assign v_wr  = in_valid && (input_type == IT_VOLUME);
  assign b_inc = in_valid && (input_type == IT_BUY);
  assign s_inc = in_valid && (input_type == IT_SELL);
  assign base_ok = p_full && v_full;

  anom_ring_avg #(.W(PW), .HIST_LOG2(HIST_LOG2)) u_price (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (p_wr),
    .din   (price_data),
    .cur   (p_cur),
    .avg   (p_avg),
    .full  (p_full)
  );

  anom_ring_avg #(.W(VW), .HIST_LOG2(HIST_LOG2)) u_volume (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (v_wr),
    .din   (volume_data),
    .cur   (v_cur),
    .avg   (v_avg),
    .full  (v_full)
  );

  assign p_dev = (price_data > p_avg) ? price_data - p_avg
                                      : p_avg - price_data;
  assign mad_acc = MW'(mad_q) * MW'(MAD_WEIGHT) + MW'(p_dev);
  assign buy_sat = (b_inc && buy_q != OMAX) ? buy_q + 1'b1 : buy_q;
  assign sell_sat = (s_inc && sell_q != OMAX) ? sell_q + 1'b1 : sell_q;
  assign mcnt_sat = (match_valid && mcnt_q != MMAX) ? mcnt_q + 1'b1
                                                    : mcnt_q;

  assign p_diff = (p_cur > prev_q) ? p_cur - prev_q : prev_q - p_cur;
  assign vola_ex = (p_diff > mad_q) ? p_diff - mad_q : '0;
  assign fall = (p_avg > p_cur) ? p_avg - p_cur : '0;

  // Previous price, MAD and velocity-window counters
  always_comb begin
    prev_d  = prev_q;
    mad_d   = mad_q;
    timer_d = timer_q + 1'b1;
    if (p_wr) begin
      prev_d = p_cur;
      mad_d  = PW'(mad_acc >> MAD_SHIFT);
    end
    if (timer_q == '1) begin
      rate_d = mcnt_sat;
      mcnt_d = '0;
      buy_d  = buy_sat >> 1;
      sell_d = sell_sat >> 1;
    end else begin
      rate_d = rate_q;
      mcnt_d = mcnt_sat;
      buy_d  = buy_sat;
      sell_d = sell_sat;
    end
  end

  // Raw detector flags with warm-up masking
  always_comb begin
    det = '0;
    det[DET_SPIKE] = p_diff > spike_thresh;
    det[DET_SURGE] = VX'(v_cur) > (VX'(v_avg) << GAIN_SHIFT);
    det[DET_VELOCITY] = RX'(rate_q) > RX'(VEL_THRESH);
    det[DET_VOLATILITY] = (|mad_q) &&
      (PX'(vola_ex) > (PX'(mad_q) << VOLA_SHIFT));
    det[DET_DRY] = (v_avg > VW'(DRY_FLOOR)) &&
      (v_cur < (v_avg >> DRY_SHIFT));
    det[DET_SPREAD] =
      ((buy_q == '0) && (sell_q > OCW'(SPREAD_MIN))) ||
      ((sell_q == '0) && (buy_q > OCW'(SPREAD_MIN)));
    det[DET_IMBALANCE] = (|buy_q) && (|sell_q) &&
      ((OX'(buy_q) > (OX'(sell_q) << IMB_SHIFT)) ||
       (OX'(sell_q) > (OX'(buy_q) << IMB_SHIFT)));
    det[DET_FLASH] = (p_avg > PW'(FLASH_FLOOR)) &&
      (fall > flash_thresh);
    if (!base_ok) begin
      det[DET_SURGE]      = 1'b0;
      det[DET_DRY]        = 1'b0;
      det[DET_VOLATILITY] = 1'b0;
      det[DET_FLASH]      = 1'b0;
    end
  end

  // Enabled flags, sticky merge, summary outputs
  always_comb begin
    bitmap_d = det & det_enable;
    sticky_d = (sticky_q & ~alert_ack) | bitmap_d;
    any_d    = |bitmap_d;
    type_d   = top_index(bitmap_d);
  end

  // Detector state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= '0;
      mad_q    <= '0;
      buy_q    <= '0;
      sell_q   <= '0;
      mcnt_q   <= '0;
      rate_q   <= '0;
      timer_q  <= '0;
      bitmap_q <= '0;
      sticky_q <= '0;
      any_q    <= 1'b0;
      type_q   <= '0;
    end else begin
      prev_q   <= prev_d;
      mad_q    <= mad_d;
      buy_q    <= buy_d;
      sell_q   <= sell_d;
      mcnt_q   <= mcnt_d;
      rate_q   <= rate_d;
      timer_q  <= timer_d;
      bitmap_q <= bitmap_d;
      sticky_q <= sticky_d;
      any_q    <= any_d;
      type_q   <= type_d;
    end
  end

`ifdef ANOMALY_EVT_CNT_EN
  logic [7:0] evt_q, evt_d;

  // Count 0->1 transitions of alert_any, saturating
  always_comb begin
    evt_d = evt_q;
    if (!any_q && any_d && evt_q != 8'hFF) evt_d = evt_q + 1'b1;
  end

  // Event counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) evt_q <= '0;
    else        evt_q <= evt_d;
  end

  assign evt_count = evt_q;
`else
  assign evt_count = '0;
`endif

  assign alert_bitmap   = bitmap_q;
  assign alert_sticky   = sticky_q;
  assign alert_any      = any_q;
  assign alert_type     = type_q;
  assign baseline_valid = base_ok;

endmodule

// File: doc/anomaly_detector_p.md
Name: anomaly_detector_p

Overview:
- Parametrised next-generation market anomaly detector, sitting between the input decoder/order book and the alert/output mux in the NanoTrade top level.
- Runs 8 parallel detectors over price, volume, match and order-pressure history, with configurable widths, history depth and window length.
- Adds features the first generation lacks: sample-valid qualification, baseline warm-up masking, per-detector enable mask, sticky alerts with per-bit acknowledge, and registered outputs.

Parameters:
- PW, 12, price width (bits)
- VW, 12, volume width (bits)
- HIST_LOG2, 3, log2 of ring-buffer depth (depth 2^HIST_LOG2; price and volume each)
- WIN_LOG2, 8, log2 of trade-velocity window length in cycles
- MCW, 5, match counter width (saturating)
- OCW, 3, buy/sell order counter width (saturating)
- VEL_THRESH, 30, velocity alert when match_rate > VEL_THRESH

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  input_type/price_data/volume_data are valid this cycle
- input_type  in  2  00 price, 01 volume, 10 buy, 11 sell
- price_data  in  PW  price sample
- volume_data  in  VW  volume sample
- match_valid  in  1  order matched this cycle (independent of in_valid)
- spike_thresh  in  PW  spike threshold
- flash_thresh  in  PW  flash-crash drop threshold
- det_enable  in  8  per-detector enable; disabled detector reads 0
- alert_ack  in  8  clear the corresponding alert_sticky bits
- alert_bitmap  out  8  registered live detector flags {flash,volatility,spread,imbalance,velocity,surge,dry,spike}
- alert_sticky  out  8  latched flags, held until acked
- alert_any  out  1  OR of alert_bitmap
- alert_type  out  3  index of highest set bit of alert_bitmap; 0 if none
- baseline_valid  out  1  both ring buffers filled at least once
- evt_count  out  8  see Optional Feature

Behaviour:
- Reset: all history, sums, averages, current/prev price, volume, MAD, counters and timers = 0. All outputs = 0.
- State updates only when in_valid=1 for price/volume/buy/sell.
- Price sample:
  - prev <= cur; cur <= price_data.
  - sum (PW+HIST_LOG2 bits) <= sum - oldest + new.
  - avg <= next_sum >> HIST_LOG2, computed from the updated sum, not the stale one.
  - MAD <= (MAD*7 + |price_data - avg|) >> 3, with a PW+3-bit intermediate; uses the pre-update avg.
- Volume sample: same ring/sum/avg scheme at VW width.
- Fill counters: price and volume each count samples and saturate at 2^HIST_LOG2. baseline_valid = both saturated.
- Buy/sell counters: saturating increment at 2^OCW-1.
- Velocity window:
  - Free-running timer of WIN_LOG2 bits.
  - At terminal count: match_rate <= match_counter plus that cycle's match; match_counter <= 0.
  - Order counters <= sat(count + inc) >> 1.
- Detectors (combinational on state, then masked by det_enable):
  - spike: |cur - prev| > spike_thresh.
  - surge: vol_cur > (vol_avg << 1).
  - velocity: match_rate > VEL_THRESH.
  - volatility: MAD > 0 and (|cur-prev| - MAD, floored at 0) > (MAD << 2).
  - dry: vol_avg > 10 and vol_cur < (vol_avg >> 2).
  - spread: (buy == 0 and sell > 2), or (sell == 0 and buy > 2).
  - imbalance: buy, sell both nonzero and (buy > sell<<2 or sell > buy<<2).
  - flash: avg > 20 and (avg - cur, floored at 0) > flash_thresh.
- Warm-up masking: surge, dry, volatility and flash are forced 0 while baseline_valid = 0.
- Shift/compare widths are extended by 2 bits so nothing overflows.
- Latency: a sample accepted at edge N appears in alert_bitmap/alert_any/alert_type after edge N+1.
- Sticky: alert_sticky <= (alert_sticky & ~alert_ack) | next_bitmap. A set and an ack in the same cycle on the same bit leave the bit set.
- Reset asserted mid-operation clears everything immediately, including sticky bits.

Optional Feature:
- ANOMALY_EVT_CNT_EN defined: evt_count is an 8-bit counter of alert_any rising edges (0 to 1 between consecutive registered values). It saturates at 255 and is cleared only by reset.
- Not defined: evt_count is tied to 0 and no counter logic is synthesised.

Decomposition:
- Package anomaly_pkg holds:
  - input_type encodings (IT_PRICE/IT_VOLUME/IT_BUY/IT_SELL)
  - detector bit indices (DET_SPIKE=0 .. DET_FLASH=7)
  - fixed constants: dry floor 10, flash floor 20, MAD weight 7, shifts
- One sub-module, anom_ring_avg, parametrised by width and HIST_LOG2. It contains the ring buffer, running sum, average and fill counter, and is instantiated for price and for volume.

Test Plan:
- Warm-up: 7 price samples of 100 followed by 1 of 40 with flash_thresh=40 -> flash stays 0 (baseline not valid). After 8 volume samples and 8 price samples of 100 then price 50 -> flash=1, alert_type=7 two edges later.
- Spike: prices 100 then 130 with spike_thresh=20 -> alert_bitmap[0]=1; sample 130 again -> bit clears, alert_sticky[0] stays 1 until alert_ack[0] pulses.
- Velocity: match_valid high for 31 cycles inside one 256-cycle window -> after terminal count, match_rate=31 and velocity=1. det_enable[3]=0 -> bitmap[3]=0.
- Imbalance/spread: 5 buys, 0 sells -> spread=1. Add 1 sell -> imbalance=1 (5 > 4), spread=0. At window end the counters halve to 2 and 0 -> both clear.
- Ack collision: alert_ack[0]=1 in the same cycle spike re-asserts -> sticky[0] remains 1. in_valid=0 with a price input -> no state change.
- Reset mid-stream: with stickies and counters set, pulse rst_n low -> all outputs 0 and baseline_valid=0. evt_count counts 3 separate alert_any episodes as 3 (macro defined), 0 otherwise.
